scalar_writeback_scheduler: RTL
===============================

Name: scalar_writeback_scheduler

Overview:
- Issue-stage scheduler for the scalar functional units (ALU, BRANCH, MUL, DIV) that share one writeback port.
- On each issue request it decodes the unit's fixed latency and reserves the writeback slot that many cycles ahead.
- It stalls issue on a writeback-slot collision or while the non-pipelined divider is busy.
- It drives the writeback-valid/tag stream and clears all reservations on a pipeline kill.

Parameters:
- TAG_W, 5, width of the destination/ROB tag carried to writeback
- DEPTH, 34, reservation window in cycles; must be >= largest latency
- LAT_ALU, 1, ALU and BRANCH latency (>=1)
- LAT_MUL, 2, MUL latency (>=1, pipelined)
- LAT_DIV, 34, DIV latency (>=1, non-pipelined)
- UNIT_ALU, 3'd0, unit code
- UNIT_BRANCH, 3'd1, unit code
- UNIT_MUL, 3'd2, unit code
- UNIT_DIV, 3'd3, unit code

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- issue_valid_i  in  1  issue request
- functional_unit_i  in  3  target unit code
- issue_tag_i  in  TAG_W  tag of issuing op
- kill_i  in  1  flush: drop all in-flight reservations
- issue_ready_o  out  1  combinational; grant = issue_valid_i & issue_ready_o
- wb_valid_o  out  1  writeback occurs this cycle (registered)
- wb_tag_o  out  TAG_W  tag writing back (registered)
- wb_unit_o  out  3  unit code writing back (registered)
- div_busy_o  out  1  divider occupied (registered)
- inflight_o  out  $clog2(DEPTH+1)  granted ops not yet written back

Behaviour:
- Latency decode L: ALU/BRANCH -> LAT_ALU; MUL -> LAT_MUL; DIV -> LAT_DIV; codes 4-7 -> LAT_ALU.
- Reservation array res_q[0..DEPTH-1]; each entry is {valid, tag, unit}.
- Each clock: res_q[k] <= res_q[k+1]; res_q[DEPTH-1] <= empty.
- On grant at cycle t: res_q[L-1] <= {1, tag, unit} overrides the shift value.
- Outputs are res_q[0] directly: wb_valid_o, wb_tag_o and wb_unit_o are high/valid exactly in cycle t+L.
- Collision check: slot_busy = (L < DEPTH) ? res_q[L].valid : 0.
- issue_ready_o = rsn_i & ~kill_i & ~slot_busy & ~(unit==DIV & div_busy_o).
- issue_ready_o may depend on functional_unit_i; no dependency on issue_valid_i.
- div_busy_o: set the cycle after a DIV grant; cleared on the edge where the DIV's entry leaves res_q[0].
- div_busy_o is therefore high during cycles t+1 .. t+L.
- A new DIV is grantable in cycle t+L+1, or in cycle t+L only if the clear is bypassed; decided: not bypassed.
- With LAT_DIV=34, DIV-to-DIV issue spacing is 35 cycles.
- inflight_o next = inflight_o + grant - wb_valid_o.
- Simultaneous grant and writeback leaves inflight_o unchanged.
- kill_i=1 at an edge: all res_q valid bits cleared, div_busy_o=0, inflight_o=0, no grant that cycle.
- A wb_valid_o already high in the kill cycle is still presented (the consumer filters it).
- After kill, wb_valid_o is 0 from the next cycle.
- Reset (rsn_i=0 at an edge): identical to kill; all outputs 0 the following cycle; issue_ready_o=0 while rsn_i=0.
- Reset mid-divide abandons the divide without any writeback.
- ALU after ALU: back-to-back grants every cycle give one wb per cycle; no stall.
- MUL granted at t blocks ALU at t+1 (both target t+2); ALU at t+2 is allowed.
- Tags are never checked or deduplicated.

Test Plan:
- Reset: hold rsn_i=0 two cycles with issue_valid_i=1 -> issue_ready_o=0, wb_valid_o=0, inflight_o=0, div_busy_o=0.
- ALU tag 5'h03 at cycle 10 -> wb_valid_o=1, wb_tag_o=5'h03, wb_unit_o=0 at cycle 11 only; 8 consecutive ALU grants -> 8 consecutive wb cycles, inflight_o peaks at 1.
- MUL tag 7 at cycle 20, ALU tag 8 at cycle 21 -> issue_ready_o=0 at 21; ALU granted at 22; wb tag 7 at 22, wb tag 8 at 23.
- DIV tag 1 at cycle 0 -> div_busy_o=1 cycles 1-34, wb tag 1 at cycle 34, second DIV ready=0 until cycle 35; ALU in cycle 33 targets 34 -> stalled; ALU in cycle 34 granted.
- DIV at cycle 0, MUL at 1, kill_i at 5 -> no wb_valid_o from cycle 6 onward, div_busy_o=0 and inflight_o=0 at cycle 6, new DIV granted at 6.
- Unit code 3'd6 tag 9 -> treated as ALU: wb at t+1 with wb_unit_o=3'd6; collides with a MUL issued the cycle before.

Source files
------------

// File: rtl/scalar_writeback_scheduler_if.sv
// Issue/writeback bundle between the issue stage and the writeback scheduler.
// slave is the scheduler side; master is the issue/consumer side.
interface scalar_writeback_scheduler_if #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 34
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               issue_valid_i;
  logic [2:0]         functional_unit_i;
  logic [TAG_W-1:0]   issue_tag_i;
  logic               kill_i;
  logic               issue_ready_o;
  logic               wb_valid_o;
  logic [TAG_W-1:0]   wb_tag_o;
  logic [2:0]         wb_unit_o;
  logic               div_busy_o;
  logic [CNT_W-1:0]   inflight_o;

  modport slave (
    input  issue_valid_i, functional_unit_i, issue_tag_i, kill_i,
    output issue_ready_o, wb_valid_o, wb_tag_o, wb_unit_o, div_busy_o, inflight_o
  );

  modport master (
    output issue_valid_i, functional_unit_i, issue_tag_i, kill_i,
    input  issue_ready_o, wb_valid_o, wb_tag_o, wb_unit_o, div_busy_o, inflight_o
  );
endinterface

// File: rtl/scalar_writeback_scheduler.sv
// Writeback-port scheduler for the scalar units: reserves the shared writeback
// slot at issue time, stalls on slot collisions and a busy divider.
module scalar_writeback_scheduler #(
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned DEPTH       = 34,
  parameter int unsigned LAT_ALU     = 1,
  parameter int unsigned LAT_MUL     = 2,
  parameter int unsigned LAT_DIV     = 34,
  parameter logic [2:0]  UNIT_ALU    = 3'd0,
  parameter logic [2:0]  UNIT_BRANCH = 3'd1,
  parameter logic [2:0]  UNIT_MUL    = 3'd2,
  parameter logic [2:0]  UNIT_DIV    = 3'd3
) (
  input logic                          clk_i,
  input logic                          rsn_i,
  scalar_writeback_scheduler_if.slave  sched_if
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [2:0]       unit;
  } res_t;

  res_t             r_res [DEPTH];
  logic             r_div_busy;
  logic [CNT_W-1:0] r_inflight;

  logic [CNT_W-1:0] w_lat;
  logic [IDX_W-1:0] w_chk_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_slot_busy;
  logic             w_div_block;
  logic             w_ready;
  logic             w_grant;
  logic             w_flush;
  logic             w_div_retire;

  // Latency decode; unknown unit codes behave like the ALU.
  always_comb begin
    w_lat = CNT_W'(LAT_ALU);
    case (sched_if.functional_unit_i)
      UNIT_ALU, UNIT_BRANCH: w_lat = CNT_W'(LAT_ALU);
      UNIT_MUL:              w_lat = CNT_W'(LAT_MUL);
      UNIT_DIV:              w_lat = CNT_W'(LAT_DIV);
      default:               w_lat = CNT_W'(LAT_ALU);
    endcase
  end

  // Slot L is the one that lands at L-1 on the next edge, i.e. our target.
  always_comb begin
    w_chk_idx   = '0;
    w_slot_busy = 1'b0;
    if (32'(w_lat) < DEPTH) begin
      w_chk_idx   = IDX_W'(w_lat);
      w_slot_busy = r_res[w_chk_idx].valid;
    end
  end

  assign w_wr_idx     = IDX_W'(w_lat - CNT_W'(1));
  assign w_div_block  = (sched_if.functional_unit_i == UNIT_DIV) & r_div_busy;
  assign w_ready      = rsn_i & ~sched_if.kill_i & ~w_slot_busy & ~w_div_block;
  assign w_grant      = sched_if.issue_valid_i & w_ready;
  assign w_flush      = ~rsn_i | sched_if.kill_i;
  assign w_div_retire = r_res[0].valid & (r_res[0].unit == UNIT_DIV);

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      for (int k = 0; k < DEPTH; k++) r_res[k] <= '0;
      r_div_busy <= 1'b0;
      r_inflight <= '0;
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) r_res[k] <= r_res[k+1];
      r_res[DEPTH-1] <= '0;
      if (w_grant) begin
        r_res[w_wr_idx] <= '{valid: 1'b1,
                             tag:   sched_if.issue_tag_i,
                             unit:  sched_if.functional_unit_i};
      end
      // Clear is not bypassed: a new DIV waits one cycle past the writeback.
      if (w_grant && (sched_if.functional_unit_i == UNIT_DIV)) begin
        r_div_busy <= 1'b1;
      end else if (w_div_retire) begin
        r_div_busy <= 1'b0;
      end
      r_inflight <= r_inflight + CNT_W'(w_grant) - CNT_W'(r_res[0].valid);
    end
  end

  assign sched_if.issue_ready_o = w_ready;
  assign sched_if.wb_valid_o    = r_res[0].valid;
  assign sched_if.wb_tag_o      = r_res[0].tag;
  assign sched_if.wb_unit_o     = r_res[0].unit;
  assign sched_if.div_busy_o    = r_div_busy;
  assign sched_if.inflight_o    = r_inflight;

endmodule
